// File: rtl/wb_mux_wdt_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_mux_wdt_pkg
// Description : Shared types, Wishbone cycle-type constants and width helpers
//               for the watchdog-protected 1:N Wishbone mux.
// Revision    : 1.0 - initial release
// ============================================================================
package wb_mux_wdt_pkg;

    // Mux control states; explicit 2-bit encoding
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DECERR = 2'd2,
        ABORT  = 2'd3
    } state_e;

    // Wishbone B3 cycle type identifiers
    localparam logic [2:0] c_cti_classic = 3'b000;
    localparam logic [2:0] c_cti_const   = 3'b001;
    localparam logic [2:0] c_cti_incr    = 3'b010;
    localparam logic [2:0] c_cti_eob     = 3'b111;

    // Index width that stays at least one bit for a single-slave build
    function automatic int unsigned idx_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Watchdog counter width; a disabled watchdog still keeps a 1-bit register
    function automatic int unsigned wdt_width(input int unsigned t);
        return (t == 0) ? 1 : $clog2(t + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/wb_mux_decode.sv
`default_nettype none
// ============================================================================
// Module      : wb_mux_decode
// Description : Priority address decoder. Slave i hits when
//               (adr & mask_i) == addr_i; the lowest hitting index wins.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_mux_decode
    import wb_mux_wdt_pkg::*;
#(
    parameter int unsigned              AW         = 32,
    parameter int unsigned              NUM_SLAVES = 4,
    parameter logic [NUM_SLAVES*AW-1:0] MATCH_ADDR = '0,
    parameter logic [NUM_SLAVES*AW-1:0] MATCH_MASK = '0
) (
    input  logic [AW-1:0]                      adr,
    output logic                               hit,
    output logic [idx_width(NUM_SLAVES)-1:0]   idx
);

    localparam int unsigned IW = idx_width(NUM_SLAVES);

    // Scan from the top down so the lowest matching index is the last writer
    always_comb begin
        hit = 1'b0;
        idx = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if ((adr & MATCH_MASK[i*AW +: AW]) == MATCH_ADDR[i*AW +: AW]) begin
                hit = 1'b1;
                idx = IW'(i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/wb_mux_wdt.sv
`default_nettype none
// ============================================================================
// Module      : wb_mux_wdt
// Description : Registered 1-master to N-slave Wishbone B3 mux with
//               decode-miss error, burst slave lock and a per-access
//               watchdog that aborts a stalled access with an err pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_mux_wdt
    import wb_mux_wdt_pkg::*;
#(
    parameter int unsigned              AW             = 32,
    parameter int unsigned              DW             = 32,
    parameter int unsigned              NUM_SLAVES     = 4,
    parameter logic [NUM_SLAVES*AW-1:0] MATCH_ADDR     = '0,
    parameter logic [NUM_SLAVES*AW-1:0] MATCH_MASK     = '0,
    parameter int unsigned              TIMEOUT_CYCLES = 256
) (
    input  logic                         wb_clk_i,
    input  logic                         wb_rst_ni,
    input  logic [AW-1:0]                wbm_adr_i,
    input  logic [DW-1:0]                wbm_dat_i,
    input  logic [DW/8-1:0]              wbm_sel_i,
    input  logic                         wbm_we_i,
    input  logic                         wbm_cyc_i,
    input  logic                         wbm_stb_i,
    input  logic [2:0]                   wbm_cti_i,
    input  logic [1:0]                   wbm_bte_i,
    output logic [DW-1:0]                wbm_dat_o,
    output logic                         wbm_ack_o,
    output logic                         wbm_err_o,
    output logic                         wbm_rty_o,
    output logic [NUM_SLAVES*AW-1:0]     wbs_adr_o,
    output logic [NUM_SLAVES*DW-1:0]     wbs_dat_o,
    output logic [NUM_SLAVES*DW/8-1:0]   wbs_sel_o,
    output logic [NUM_SLAVES-1:0]        wbs_we_o,
    output logic [NUM_SLAVES-1:0]        wbs_cyc_o,
    output logic [NUM_SLAVES-1:0]        wbs_stb_o,
    output logic [NUM_SLAVES*3-1:0]      wbs_cti_o,
    output logic [NUM_SLAVES*2-1:0]      wbs_bte_o,
    input  logic [NUM_SLAVES*DW-1:0]     wbs_dat_i,
    input  logic [NUM_SLAVES-1:0]        wbs_ack_i,
    input  logic [NUM_SLAVES-1:0]        wbs_err_i,
    input  logic [NUM_SLAVES-1:0]        wbs_rty_i,
    output logic                         timeout_o
);

    localparam int unsigned IW = idx_width(NUM_SLAVES);
    localparam int unsigned WW = wdt_width(TIMEOUT_CYCLES);
    localparam bit          c_wdt_en   = (TIMEOUT_CYCLES != 0);
    localparam logic [WW-1:0] c_wdt_last =
        WW'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);

    state_e          r_state, w_state_nxt;
    logic [IW-1:0]   r_sel_idx, w_sel_nxt;
    logic [WW-1:0]   r_wdt, w_wdt_nxt;

    logic            w_dec_hit;
    logic [IW-1:0]   w_dec_idx;
    logic            w_active;
    logic            w_live;
    logic [DW-1:0]   w_sel_dat;
    logic            w_sel_ack, w_sel_err, w_sel_rty;
    logic            w_resp;
    logic            w_burst;

    wb_mux_decode #(
        .AW         (AW),
        .NUM_SLAVES (NUM_SLAVES),
        .MATCH_ADDR (MATCH_ADDR),
        .MATCH_MASK (MATCH_MASK)
    ) u_decode (
        .adr (wbm_adr_i),
        .hit (w_dec_hit),
        .idx (w_dec_idx)
    );

    // Address/data/control are broadcast; only cyc/stb are steered
    generate
        for (genvar i = 0; i < NUM_SLAVES; i++) begin : g_slot
            assign wbs_adr_o[i*AW +: AW]       = wbm_adr_i;
            assign wbs_dat_o[i*DW +: DW]       = wbm_dat_i;
            assign wbs_sel_o[i*DW/8 +: DW/8]   = wbm_sel_i;
            assign wbs_we_o[i]                 = wbm_we_i;
            assign wbs_cti_o[i*3 +: 3]         = wbm_cti_i;
            assign wbs_bte_o[i*2 +: 2]         = wbm_bte_i;
            assign wbs_cyc_o[i] = w_live & (r_sel_idx == IW'(i));
            assign wbs_stb_o[i] = w_live & wbm_stb_i & (r_sel_idx == IW'(i));
        end
    endgenerate

    assign w_active = (r_state == ACTIVE);
    // A locked slave only sees cyc while the master holds cyc, so its
    // responses are ignored whenever its cyc is low
    assign w_live   = w_active & wbm_cyc_i;

    // Pick the locked slave's data and response lines
    always_comb begin
        w_sel_dat = '0;
        w_sel_ack = 1'b0;
        w_sel_err = 1'b0;
        w_sel_rty = 1'b0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (r_sel_idx == IW'(i)) begin
                w_sel_dat = wbs_dat_i[i*DW +: DW];
                w_sel_ack = wbs_ack_i[i];
                w_sel_err = wbs_err_i[i];
                w_sel_rty = wbs_rty_i[i];
            end
        end
    end

    assign w_resp  = w_live & (w_sel_ack | w_sel_err | w_sel_rty);
    assign w_burst = (wbm_cti_i == c_cti_const) || (wbm_cti_i == c_cti_incr);

    assign wbm_dat_o = w_active ? w_sel_dat : '0;
    assign wbm_ack_o = w_live & w_sel_ack;
    assign wbm_rty_o = w_live & w_sel_rty;
    assign wbm_err_o = (w_live & w_sel_err) | (r_state == DECERR) | (r_state == ABORT);
    assign timeout_o = (r_state == ABORT);

    // State, slave lock and watchdog registers
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_state   <= IDLE;
            r_sel_idx <= '0;
            r_wdt     <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_sel_idx <= w_sel_nxt;
            r_wdt     <= w_wdt_nxt;
        end
    end

    // Next-state: decode on a new access, hold lock through bursts, and
    // abort when the wait counter expires without a response
    always_comb begin
        w_state_nxt = r_state;
        w_sel_nxt   = r_sel_idx;
        w_wdt_nxt   = r_wdt;
        case (r_state)
            IDLE: begin
                w_wdt_nxt = '0;
                if (wbm_cyc_i && wbm_stb_i) begin
                    if (w_dec_hit) begin
                        w_state_nxt = ACTIVE;
                        w_sel_nxt   = w_dec_idx;
                    end else begin
                        w_state_nxt = DECERR;
                    end
                end
            end
            ACTIVE: begin
                if (!wbm_cyc_i) begin
                    w_state_nxt = IDLE;
                    w_wdt_nxt   = '0;
                end else if (w_resp) begin
                    // A response in the expiry cycle still wins over abort
                    w_wdt_nxt = '0;
                    if (!w_burst) begin
                        w_state_nxt = IDLE;
                    end
                end else if (wbm_stb_i && c_wdt_en) begin
                    if (r_wdt == c_wdt_last) begin
                        w_state_nxt = ABORT;
                        w_wdt_nxt   = '0;
                    end else if (r_wdt != '1) begin
                        w_wdt_nxt = r_wdt + 1'b1;
                    end
                end
            end
            DECERR, ABORT: begin
                w_state_nxt = IDLE;
                w_wdt_nxt   = '0;
            end
            default: begin
                w_state_nxt = IDLE;
                w_wdt_nxt   = '0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_wb_mux_wdt.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_mux_wdt
// Description : Directed self-checking bench for wb_mux_wdt with four
//               256-byte slave segments and a 16-cycle watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_mux_wdt;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned N  = 4;
    localparam logic [N*AW-1:0] MADDR = {32'h0000_0300, 32'h0000_0200,
                                         32'h0000_0100, 32'h0000_0000};
    localparam logic [N*AW-1:0] MMASK = {4{32'hFFFF_FF00}};

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [AW-1:0]      m_adr = '0;
    logic [DW-1:0]      m_dat = '0;
    logic [DW/8-1:0]    m_sel = '0;
    logic               m_we = 1'b0;
    logic               m_cyc = 1'b0;
    logic               m_stb = 1'b0;
    logic [2:0]         m_cti = '0;
    logic [1:0]         m_bte = '0;
    logic [DW-1:0]      m_rdat;
    logic               m_ack, m_err, m_rty;
    logic [N*AW-1:0]    s_adr;
    logic [N*DW-1:0]    s_wdat;
    logic [N*DW/8-1:0]  s_sel;
    logic [N-1:0]       s_we, s_cyc, s_stb;
    logic [N*3-1:0]     s_cti;
    logic [N*2-1:0]     s_bte;
    logic [N*DW-1:0]    s_rdat;
    logic [N-1:0]       s_ack;
    logic               tmo;

    logic [N-1:0]       ack_en  = 4'b1111;
    logic [N-1:0]       man_ack = 4'b0000;
    logic [31:0]        last_wr [N];
    int                 wr_cnt  [N];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    wb_mux_wdt #(
        .AW (AW), .DW (DW), .NUM_SLAVES (N),
        .MATCH_ADDR (MADDR), .MATCH_MASK (MMASK),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .wb_clk_i  (clk),     .wb_rst_ni (rst_n),
        .wbm_adr_i (m_adr),   .wbm_dat_i (m_dat),   .wbm_sel_i (m_sel),
        .wbm_we_i  (m_we),    .wbm_cyc_i (m_cyc),   .wbm_stb_i (m_stb),
        .wbm_cti_i (m_cti),   .wbm_bte_i (m_bte),
        .wbm_dat_o (m_rdat),  .wbm_ack_o (m_ack),   .wbm_err_o (m_err),
        .wbm_rty_o (m_rty),
        .wbs_adr_o (s_adr),   .wbs_dat_o (s_wdat),  .wbs_sel_o (s_sel),
        .wbs_we_o  (s_we),    .wbs_cyc_o (s_cyc),   .wbs_stb_o (s_stb),
        .wbs_cti_o (s_cti),   .wbs_bte_o (s_bte),
        .wbs_dat_i (s_rdat),  .wbs_ack_i (s_ack),
        .wbs_err_i ('0),      .wbs_rty_i ('0),
        .timeout_o (tmo)
    );

    // Zero-wait slaves: ack immediately when enabled, plus a manual override
    assign s_ack = (s_cyc & s_stb & ack_en) | man_ack;

    // Slave read data encodes slave number and low address bits
    generate
        for (genvar i = 0; i < N; i++) begin : g_sl
            assign s_rdat[i*DW +: DW] = 32'hA000_0000 | (32'(i) << 24)
                                      | {16'h0, s_adr[i*AW +: 16]};
        end
    endgenerate

    // Record the last accepted write per slave
    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (s_cyc[i] && s_stb[i] && s_ack[i] && s_we[i]) begin
                last_wr[i] <= s_wdat[i*DW +: DW];
                wr_cnt[i]  <= wr_cnt[i] + 1;
            end
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got,
                            input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic next_cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic mid;
        @(negedge clk);
    endtask

    task automatic master_idle;
        m_cyc = 1'b0;
        m_stb = 1'b0;
        m_we  = 1'b0;
        m_cti = 3'b000;
    endtask

    task automatic master_req(input logic [31:0] adr, input logic we,
                              input logic [31:0] dat, input logic [2:0] cti);
        m_adr = adr;
        m_we  = we;
        m_dat = dat;
        m_sel = 4'hF;
        m_cti = cti;
        m_cyc = 1'b1;
        m_stb = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            last_wr[i] = '0;
            wr_cnt[i]  = 0;
        end

        // Reset state
        mid;
        check_eq("rst_cyc", {60'h0, s_cyc}, 64'h0);
        check_eq("rst_resp", {61'h0, m_ack, m_err, m_rty}, 64'h0);
        check_eq("rst_tmo", {63'h0, tmo}, 64'h0);
        check_eq("rst_dat", {32'h0, m_rdat}, 64'h0);
        next_cyc;
        rst_n = 1'b1;

        // Stray slave ack with no cycle open must not reach the master
        next_cyc;
        man_ack = 4'b1111;
        mid;
        check_eq("stray_ack", {63'h0, m_ack}, 64'h0);
        next_cyc;
        man_ack = 4'b0000;

        // Single write 0x204 -> slave 2, one decode cycle
        master_req(32'h204, 1'b1, 32'hDEAD_BEEF, 3'b000);
        mid;
        check_eq("wr_decode_stb", {60'h0, s_stb}, 64'h0);
        next_cyc;
        mid;
        check_eq("wr_stb", {60'h0, s_stb}, 64'h4);
        check_eq("wr_ack", {63'h0, m_ack}, 64'h1);
        check_eq("wr_adr2", {32'h0, s_adr[2*AW +: AW]}, 64'h204);
        next_cyc;
        master_idle;
        mid;
        check_eq("wr_data", {32'h0, last_wr[2]}, 64'hDEAD_BEEF);
        check_eq("wr_cyc_off", {60'h0, s_cyc}, 64'h0);

        // Decode miss
        next_cyc;
        master_req(32'h1000, 1'b0, 32'h0, 3'b000);
        mid;
        check_eq("miss_idle_err", {63'h0, m_err}, 64'h0);
        next_cyc;
        mid;
        check_eq("miss_err", {63'h0, m_err}, 64'h1);
        check_eq("miss_cyc", {60'h0, s_cyc}, 64'h0);
        check_eq("miss_tmo", {63'h0, tmo}, 64'h0);
        next_cyc;
        master_idle;
        mid;
        check_eq("miss_err_once", {63'h0, m_err}, 64'h0);

        // 4-beat incrementing burst on slave 1, decoded once
        next_cyc;
        master_req(32'h100, 1'b0, 32'h0, 3'b010);
        mid;
        check_eq("bst_decode_stb", {60'h0, s_stb}, 64'h0);
        for (int b = 0; b < 4; b++) begin
            next_cyc;
            m_adr = 32'h100 + 32'(b * 4);
            m_cti = (b == 3) ? 3'b111 : 3'b010;
            mid;
            check_eq("bst_stb", {60'h0, s_stb}, 64'h2);
            check_eq("bst_ack", {63'h0, m_ack}, 64'h1);
            check_eq("bst_dat", {32'h0, m_rdat}, {32'h0, 32'hA100_0100 + 32'(b * 4)});
        end
        next_cyc;
        master_idle;
        mid;
        check_eq("bst_end_cyc", {60'h0, s_cyc}, 64'h0);

        // Slave 3 never answers -> abort after 16 wait cycles
        ack_en = 4'b0111;
        next_cyc;
        master_req(32'h300, 1'b0, 32'h0, 3'b000);
        mid;
        for (int k = 1; k <= 16; k++) begin
            next_cyc;
            mid;
            check_eq("wdt_wait_err", {63'h0, m_err}, 64'h0);
        end
        check_eq("wdt_wait_cyc", {60'h0, s_cyc}, 64'h8);
        next_cyc;
        mid;
        check_eq("wdt_abort_err", {63'h0, m_err}, 64'h1);
        check_eq("wdt_abort_tmo", {63'h0, tmo}, 64'h1);
        check_eq("wdt_abort_cyc", {60'h0, s_cyc}, 64'h0);
        next_cyc;
        master_idle;
        mid;
        check_eq("wdt_tmo_pulse", {63'h0, tmo}, 64'h0);

        // Ack arriving in the 16th wait cycle beats the watchdog
        next_cyc;
        master_req(32'h300, 1'b0, 32'h0, 3'b000);
        for (int k = 1; k <= 15; k++) next_cyc;
        next_cyc;
        man_ack = 4'b1000;
        mid;
        check_eq("late_ack", {63'h0, m_ack}, 64'h1);
        check_eq("late_err", {63'h0, m_err}, 64'h0);
        check_eq("late_tmo", {63'h0, tmo}, 64'h0);
        next_cyc;
        man_ack = 4'b0000;
        master_idle;
        mid;
        check_eq("late_no_abort", {62'h0, m_err, tmo}, 64'h0);
        ack_en = 4'b1111;

        // Reset asserted mid-burst drops everything at once
        next_cyc;
        master_req(32'h200, 1'b0, 32'h0, 3'b010);
        next_cyc;
        mid;
        check_eq("rb_stb", {60'h0, s_stb}, 64'h4);
        rst_n = 1'b0;
        #1;
        check_eq("rb_cyc", {60'h0, s_cyc}, 64'h0);
        check_eq("rb_stb0", {60'h0, s_stb}, 64'h0);
        check_eq("rb_resp", {61'h0, m_ack, m_err, m_rty}, 64'h0);
        check_eq("rb_dat", {32'h0, m_rdat}, 64'h0);
        master_idle;
        next_cyc;
        rst_n = 1'b1;
        next_cyc;

        for (int i = 0; i < N; i++)
            $display("slave %0d writes %0d", i, wr_cnt[i]);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    // Safety net so the run always terminates
    initial begin
        #200000;
        $display("FAIL global_timeout: got hang expected finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
